wash_cycle_ctrl: RTL and testbench

WASH_CYCLE_CTRL -- requirements
Module: wash_cycle_ctrl

---
 rtl/wash_cycle_ctrl.sv | 106 ++++++++++
 tb/tb_wash_cycle_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine phase sequencer: IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE.
// Define DOUBLE_WASH_EN to enable the optional second wash+rinse pass.
module wash_cycle_ctrl (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Coin_In,
    input  logic       Double_Wash,
    input  logic       Timer_Pause,
    input  logic       Time_Event,
    output logic [2:0] Timer_Encoding,
    output logic       Pause_Enable_T,
    output logic       Timer_Clear_n,
    output logic       Wash_Done,
    output logic [2:0] State_Out
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        FILL  = 3'b001,
        WASH  = 3'b010,
        RINSE = 3'b011,
        SPIN  = 3'b100
    } state_t;

    state_t state_q, state_d;
    logic   pause_q, pause_d;
    logic   clear_n_q, clear_n_d;
    logic   done_q, done_d;
    logic   advance;

`ifdef DOUBLE_WASH_EN
    logic dbl_q, dbl_d;
    logic pass_q, pass_d;
`else
    logic unused_double_wash;
    assign unused_double_wash = Double_Wash;
`endif

    always_comb begin
        state_d = state_q;
        // A paused timer must never advance the phase.
        advance = Time_Event && !pause_q;

        case (state_q)
            IDLE:    if (Coin_In) state_d = FILL;
            FILL:    if (advance) state_d = WASH;
            WASH:    if (advance) state_d = RINSE;
            RINSE: begin
                if (advance) begin
`ifdef DOUBLE_WASH_EN
                    state_d = (dbl_q && !pass_q) ? WASH : SPIN;
`else
                    state_d = SPIN;
`endif
                end
            end
            SPIN:    if (advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef DOUBLE_WASH_EN
        dbl_d  = dbl_q;
        pass_d = pass_q;
        if (state_q == IDLE && state_d == FILL) dbl_d = Double_Wash;
        if (state_q == RINSE && state_d == WASH) pass_d = 1'b1;
        if (state_d == IDLE) begin
            dbl_d  = 1'b0;
            pass_d = 1'b0;
        end
`endif

        pause_d   = (state_q == SPIN) && (state_d == SPIN) && Timer_Pause;
        // Timer held in restart while idle and for one cycle after each active-phase change.
        clear_n_d = (state_d != IDLE) && !((state_q != IDLE) && (state_d != state_q));
        done_d    = (state_q == SPIN) && (state_d == IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            pause_q   <= 1'b0;
            clear_n_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef DOUBLE_WASH_EN
            dbl_q     <= 1'b0;
            pass_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pause_q   <= pause_d;
            clear_n_q <= clear_n_d;
            done_q    <= done_d;
`ifdef DOUBLE_WASH_EN
            dbl_q     <= dbl_d;
            pass_q    <= pass_d;
`endif
        end
    end

    assign Timer_Encoding = state_q;
    assign State_Out      = state_q;
    assign Pause_Enable_T = pause_q;
    assign Timer_Clear_n  = clear_n_q;
    assign Wash_Done      = done_q;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Directed bench for wash_cycle_ctrl: a vector table plus double-pass sequences.
// Expected double-pass behaviour follows whether DOUBLE_WASH_EN is defined.
module tb_wash_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst, coin_in, double_wash, timer_pause, time_event;
    logic [2:0] timer_encoding, state_out;
    logic       pause_enable_t, timer_clear_n, wash_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       coin;
        logic       dbl;
        logic       pause;
        logic       tev;
        logic [2:0] exp_state;
        logic       exp_clr_n;
        logic       exp_done;
        logic       exp_pe;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    wash_cycle_ctrl dut (
        .Clk            (clk),
        .Rst            (rst),
        .Coin_In        (coin_in),
        .Double_Wash    (double_wash),
        .Timer_Pause    (timer_pause),
        .Time_Event     (time_event),
        .Timer_Encoding (timer_encoding),
        .Pause_Enable_T (pause_enable_t),
        .Timer_Clear_n  (timer_clear_n),
        .Wash_Done      (wash_done),
        .State_Out      (state_out)
    );

    always #5 clk = ~clk;

    task automatic add_vec(input logic r, input logic c, input logic d, input logic p,
                           input logic t, input logic [2:0] st, input logic clr,
                           input logic dn, input logic pe, input string tag);
        vec_t v;
        v.rst = r; v.coin = c; v.dbl = d; v.pause = p; v.tev = t;
        v.exp_state = st; v.exp_clr_n = clr; v.exp_done = dn; v.exp_pe = pe; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Drive one set of inputs across a single rising edge; outputs sampled 1 time unit later.
    task automatic apply_stimulus(input logic r, input logic c, input logic d,
                                  input logic p, input logic t);
        rst = r; coin_in = c; double_wash = d; timer_pause = p; time_event = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [2:0] act, input logic [2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic clr,
                             input logic dn, input logic pe);
        check_output({tag, ".state_out"}, state_out, st);
        check_output({tag, ".timer_encoding"}, timer_encoding, st);
        check_output({tag, ".clear_n"}, {2'b00, timer_clear_n}, {2'b00, clr});
        check_output({tag, ".wash_done"}, {2'b00, wash_done}, {2'b00, dn});
        check_output({tag, ".pause_en"}, {2'b00, pause_enable_t}, {2'b00, pe});
    endtask

    // Full cycle from IDLE; each phase change is followed by one quiet cycle.
    task automatic run_pass(input logic dbl, input string tag);
        logic [2:0] seq[$];
`ifdef DOUBLE_WASH_EN
        if (dbl) seq = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0};
        else     seq = '{3'd2, 3'd3, 3'd4, 3'd0};
`else
        seq = '{3'd2, 3'd3, 3'd4, 3'd0};
`endif
        apply_stimulus(1'b0, 1'b1, dbl, 1'b0, 1'b0);
        check_all({tag, ".start"}, 3'd1, 1'b1, 1'b0, 1'b0);
        foreach (seq[i]) begin
            apply_stimulus(1'b0, 1'b0, ~dbl, 1'b0, 1'b1);
            check_all($sformatf("%s.step%0d", tag, i), seq[i], 1'b0,
                      seq[i] == 3'd0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_all($sformatf("%s.hold%0d", tag, i), seq[i], seq[i] != 3'd0,
                      1'b0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; coin_in = 1'b0; double_wash = 1'b0; timer_pause = 1'b0; time_event = 1'b0;

        //      rst coin dbl pause tev  state clr done pe
        add_vec(1, 0, 0, 0, 0, 3'd0, 0, 0, 0, "reset0");
        add_vec(1, 1, 0, 0, 1, 3'd0, 0, 0, 0, "reset1");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "coin_start");
        add_vec(0, 0, 0, 0, 0, 3'd1, 1, 0, 0, "fill_hold");
        add_vec(0, 0, 0, 0, 1, 3'd2, 0, 0, 0, "fill_to_wash");
        add_vec(0, 1, 1, 1, 0, 3'd2, 1, 0, 0, "wash_coin_pause");
        add_vec(0, 1, 0, 0, 1, 3'd3, 0, 0, 0, "wash_to_rinse");
        add_vec(0, 0, 0, 0, 0, 3'd3, 1, 0, 0, "rinse_hold");
        add_vec(0, 0, 0, 0, 1, 3'd4, 0, 0, 0, "rinse_to_spin");
        add_vec(0, 0, 0, 1, 0, 3'd4, 1, 0, 1, "spin_pause");
        add_vec(0, 0, 0, 1, 1, 3'd4, 1, 0, 1, "paused_tev");
        add_vec(0, 0, 0, 0, 0, 3'd4, 1, 0, 0, "resume");
        add_vec(0, 0, 0, 0, 1, 3'd0, 0, 1, 0, "spin_done");
        add_vec(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, "idle_after");
        add_vec(0, 0, 0, 0, 1, 3'd0, 0, 0, 0, "idle_tev");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "race_start");
        add_vec(0, 0, 0, 0, 1, 3'd2, 0, 0, 0, "race_wash");
        add_vec(0, 0, 0, 0, 1, 3'd3, 0, 0, 0, "race_rinse");
        add_vec(0, 0, 0, 0, 1, 3'd4, 0, 0, 0, "race_spin");
        add_vec(0, 0, 0, 1, 1, 3'd0, 0, 1, 0, "tev_beats_pause");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "rst_start");
        add_vec(0, 0, 0, 0, 1, 3'd2, 0, 0, 0, "rst_wash");
        add_vec(0, 0, 0, 0, 1, 3'd3, 0, 0, 0, "rst_rinse");
        add_vec(1, 0, 0, 0, 1, 3'd0, 0, 0, 0, "rst_in_rinse");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "rp_start");
        add_vec(0, 0, 0, 0, 1, 3'd2, 0, 0, 0, "rp_wash");
        add_vec(0, 0, 0, 0, 1, 3'd3, 0, 0, 0, "rp_rinse");
        add_vec(0, 0, 0, 0, 1, 3'd4, 0, 0, 0, "rp_spin");
        add_vec(0, 0, 0, 1, 0, 3'd4, 1, 0, 1, "rp_pause");
        add_vec(1, 0, 0, 1, 1, 3'd0, 0, 0, 0, "rst_paused_spin");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "held_start");
        add_vec(0, 1, 0, 0, 1, 3'd2, 0, 0, 0, "held_wash");
        add_vec(0, 1, 0, 0, 1, 3'd3, 0, 0, 0, "held_rinse");
        add_vec(0, 1, 0, 0, 1, 3'd4, 0, 0, 0, "held_spin");
        add_vec(0, 1, 0, 0, 1, 3'd0, 0, 1, 0, "done_coin_held");
        add_vec(0, 1, 0, 0, 0, 3'd1, 1, 0, 0, "restart");

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].rst, vecs[i].coin, vecs[i].dbl, vecs[i].pause, vecs[i].tev);
            check_all(vecs[i].tag, vecs[i].exp_state, vecs[i].exp_clr_n,
                      vecs[i].exp_done, vecs[i].exp_pe);
        end

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all("seq_reset", 3'd0, 1'b0, 1'b0, 1'b0);
        run_pass(1'b1, "dbl_pass");
        run_pass(1'b0, "single_after_dbl");
        run_pass(1'b1, "dbl_again");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
